// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flush, and a
// data-memory request/ack FSM that freezes the pipeline while an access waits.
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT_W = 8,
   parameter int CNT_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [4:0]       IF_ID_Rs1_i,
   input  logic [4:0]       IF_ID_Rs2_i,
   input  logic             IF_ID_UsesRs2_i,
   input  logic             ID_EX_MemRead_i,
   input  logic [4:0]       ID_EX_Rd_i,
   input  logic             Branch_taken_i,
   input  logic             EX_MEM_MemRead_i,
   input  logic             EX_MEM_MemWrite_i,
   input  logic             mem_ack_i,
   output logic             mem_req_o,
   output logic             PCWrite_o,
   output logic             IF_ID_Write_o,
   output logic             NoOp_o,
   output logic             Flush_o,
   output logic             Stall_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   typedef enum logic [1:0] {M_IDLE, M_WAIT, M_ERR} state_t;

   // Last wait-counter value before it would become all-ones.
   localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

   state_t               state;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 access, hazard, req, stall;

   assign access = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;
   assign hazard = ID_EX_MemRead_i && (ID_EX_Rd_i != 5'd0) &&
                   ((ID_EX_Rd_i == IF_ID_Rs1_i) ||
                    (IF_ID_UsesRs2_i && (ID_EX_Rd_i == IF_ID_Rs2_i)));

   always_comb begin
      req   = (state == M_WAIT) || ((state == M_IDLE) && access);
      stall = (req && !mem_ack_i) || (state == M_ERR);
   end

   always_comb begin
      mem_req_o     = req;
      Stall_o       = stall;
      PCWrite_o     = 1'b1;
      IF_ID_Write_o = 1'b1;
      NoOp_o        = 1'b0;
      Flush_o       = Branch_taken_i;
      if (!rst_i) begin
         mem_req_o     = 1'b0;
         Stall_o       = 1'b0;
         PCWrite_o     = 1'b0;
         IF_ID_Write_o = 1'b0;
         NoOp_o        = 1'b1;
         Flush_o       = 1'b0;
      end else if (stall) begin
         PCWrite_o     = 1'b0;
         IF_ID_Write_o = 1'b0;
         Flush_o       = 1'b0;
      end else if (!start_i || hazard) begin
         PCWrite_o     = 1'b0;
         IF_ID_Write_o = 1'b0;
         NoOp_o        = 1'b1;
         Flush_o       = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= M_IDLE;
         wait_cnt <= '0;
         err_o    <= 1'b0;
      end else begin
         case (state)
            M_IDLE: begin
               if (access && !mem_ack_i) begin
                  state    <= M_WAIT;
                  wait_cnt <= '0;
               end
            end
            M_WAIT: begin
               // An ack arriving on the timeout cycle still completes normally.
               if (mem_ack_i) begin
                  state <= M_IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  state    <= M_ERR;
                  wait_cnt <= wait_cnt + 1'b1;
                  err_o    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            M_ERR:   err_o <= 1'b1;
            default: state <= M_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cycles_o <= '0;
      end else if ((stall || (hazard && start_i)) && (stall_cycles_o != {CNT_W{1'b1}})) begin
         stall_cycles_o <= stall_cycles_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, hand sequences for the
// multi-cycle memory cases, and random stimulus against a reference model.
module tb_pipeline_hazard_ctrl;

   localparam int TW = 3;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int TMO = (1 << TW) - 1;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic start_i = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic use2 = 1'b0, idmr = 1'b0, br = 1'b0, exmr = 1'b0, exmw = 1'b0, ack = 1'b0;
   logic req, pcw, ifw, noop, flush, stall, err;
   logic [CW-1:0] cnt;

   int total = 0;
   int bad = 0;

   pipeline_hazard_ctrl #(.TIMEOUT_W(TW), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .IF_ID_Rs1_i(rs1), .IF_ID_Rs2_i(rs2), .IF_ID_UsesRs2_i(use2),
      .ID_EX_MemRead_i(idmr), .ID_EX_Rd_i(rd), .Branch_taken_i(br),
      .EX_MEM_MemRead_i(exmr), .EX_MEM_MemWrite_i(exmw), .mem_ack_i(ack),
      .mem_req_o(req), .PCWrite_o(pcw), .IF_ID_Write_o(ifw), .NoOp_o(noop),
      .Flush_o(flush), .Stall_o(stall), .err_o(err), .stall_cycles_o(cnt)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit st; bit [4:0] r1; bit [4:0] r2; bit u2; bit lmr; bit [4:0] d; bit b;
      bit mr; bit mw; bit a;
      bit [5:0] exp; // {req, stall, pcw, ifw, noop, flush}
   } vec_t;

   vec_t vt[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      start_i = 1'b1; rs1 = '0; rs2 = '0; use2 = 1'b0; idmr = 1'b0; rd = '0;
      br = 1'b0; exmr = 1'b0; exmw = 1'b0; ack = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      idle_inputs();
      tick();
      rst_i = 1'b1;
   endtask

   function automatic vec_t mk(bit st, bit [4:0] r1, bit [4:0] r2, bit u2, bit lmr,
                               bit [4:0] d, bit b, bit mr, bit mw, bit a, bit [5:0] e);
      vec_t v;
      v.st = st; v.r1 = r1; v.r2 = r2; v.u2 = u2; v.lmr = lmr; v.d = d; v.b = b;
      v.mr = mr; v.mw = mw; v.a = a; v.exp = e;
      return v;
   endfunction

   // Reference model: number of wait cycles elapsed (-1 = no access outstanding).
   int  m_wait;
   bit  m_err;
   int  m_cnt;

   initial begin
      int scount;
      //           st r1 r2 u2 lmr rd br mr mw ack   req stl pcw ifw noop fl
      vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001100);
      vt[1]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001101);
      vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000010);
      vt[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000010);
      vt[4]  = mk(1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 6'b000010);
      vt[5]  = mk(1, 3, 9, 1, 1, 9, 1, 0, 0, 0, 6'b000010);
      vt[6]  = mk(1, 3, 9, 0, 1, 9, 1, 0, 0, 0, 6'b001101);
      vt[7]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 6'b001100);
      vt[8]  = mk(1, 5, 0, 0, 0, 5, 0, 0, 0, 0, 6'b001100);
      vt[9]  = mk(1, 5, 0, 0, 1, 5, 1, 1, 0, 0, 6'b110000);
      vt[10] = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 6'b101101);
      vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b110000);
      vt[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b001100);

      // Reset held 3 cycles with an access pending.
      rst_i = 1'b0;
      idle_inputs();
      exmr = 1'b1;
      repeat (3) tick();
      chk("rst_outs", {req, stall, pcw, ifw, noop, flush}, 6'b000010);
      chk("rst_cnt", cnt, 0);
      chk("rst_err", err, 0);
      exmr = 1'b0;
      rst_i = 1'b1;

      // Vector table: each applied from a freshly reset state, no clock edge taken.
      for (int i = 0; i < 13; i++) begin
         rst_i = 1'b0;
         tick();
         start_i = vt[i].st; rs1 = vt[i].r1; rs2 = vt[i].r2; use2 = vt[i].u2;
         idmr = vt[i].lmr; rd = vt[i].d; br = vt[i].b; exmr = vt[i].mr;
         exmw = vt[i].mw; ack = vt[i].a;
         rst_i = 1'b1;
         #1;
         chk($sformatf("vec%0d", i), {req, stall, pcw, ifw, noop, flush}, vt[i].exp);
         rst_i = 1'b0;
      end

      // Load-use bubble lasts one cycle; Rd = 0 never bubbles.
      do_reset();
      idmr = 1'b1; rd = 5'd5; rs1 = 5'd5;
      #1;
      chk("lu_bubble", {pcw, ifw, noop}, 3'b001);
      tick();
      idmr = 1'b0;
      #1;
      chk("lu_cnt", cnt, 1);
      chk("lu_release", {pcw, ifw, noop}, 3'b110);
      idmr = 1'b1; rd = 5'd0; rs1 = 5'd0;
      #1;
      chk("lu_rd0", {pcw, noop}, 2'b10);
      tick();
      chk("lu_rd0_cnt", cnt, 1);

      // Store waits: ack after 3 low cycles.
      do_reset();
      exmw = 1'b1;
      scount = 0;
      for (int i = 0; i < 4; i++) begin
         ack = (i == 3);
         #1;
         chk($sformatf("mw_req%0d", i), req, 1);
         chk($sformatf("mw_noop%0d", i), noop, 0);
         scount += int'(stall);
         tick();
      end
      exmw = 1'b0; ack = 1'b0;
      #1;
      chk("mw_stalls", scount, 3);
      chk("mw_cnt", cnt, 3);
      chk("mw_after", {req, stall, pcw}, 3'b001);
      // Zero-wait access.
      exmw = 1'b1; ack = 1'b1;
      #1;
      chk("zw_outs", {req, stall, pcw}, 3'b101);
      tick();
      exmw = 1'b0; ack = 1'b0;
      chk("zw_cnt", cnt, 3);

      // Timeout: idle cycle plus TMO wait cycles without ack.
      do_reset();
      exmr = 1'b1;
      repeat (TMO) tick();
      chk("to_not_yet", err, 0);
      tick();
      chk("to_err", err, 1);
      chk("to_outs", {req, stall, pcw, noop}, 4'b0100);
      ack = 1'b1;
      tick();
      chk("to_sticky", {err, stall, req}, 3'b110);
      ack = 1'b0;
      do_reset();
      chk("to_clr", err, 0);
      // Ack on the final wait cycle wins over the timeout.
      exmr = 1'b1;
      repeat (TMO) tick();
      ack = 1'b1;
      #1;
      chk("to_lastack_stall", stall, 0);
      tick();
      exmr = 1'b0; ack = 1'b0;
      #1;
      chk("to_lastack_err", {err, req, stall}, 3'b000);

      // Saturation with a permanent stall.
      do_reset();
      exmr = 1'b1;
      repeat (20) tick();
      chk("sat20", cnt, CMAX);
      repeat (2) tick();
      chk("sat22", cnt, CMAX);

      // Random stimulus vs. reference model.
      do_reset();
      m_wait = -1; m_err = 0; m_cnt = 0;
      for (int n = 0; n < 1500; n++) begin
         bit acc, haz, req_e, stl_e;
         bit [5:0] exp;
         start_i = ($urandom_range(0, 7) != 0);
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
         rd = 5'($urandom_range(0, 3)); use2 = 1'($urandom);
         idmr = 1'($urandom); br = 1'($urandom);
         exmr = ($urandom_range(0, 3) == 0); exmw = ($urandom_range(0, 4) == 0);
         ack = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 59) == 0) begin
            rst_i = 1'b0;
            #1;
            chk("rnd_rst", {req, stall, pcw, ifw, noop, flush}, 6'b000010);
            tick();
            m_wait = -1; m_err = 0; m_cnt = 0;
            chk("rnd_rst_reg", {err, 4'(cnt)}, 5'b0);
            rst_i = 1'b1;
            continue;
         end
         acc   = exmr | exmw;
         haz   = idmr && rd != 0 && (rd == rs1 || (use2 && rd == rs2));
         req_e = m_err ? 1'b0 : (m_wait >= 0 ? 1'b1 : acc);
         stl_e = m_err || (req_e && !ack);
         if (stl_e)         exp = {req_e, 5'b10000};
         else if (!start_i) exp = {req_e, 5'b00010};
         else if (haz)      exp = {req_e, 5'b00010};
         else               exp = {req_e, 4'b0110, br};
         #1;
         chk("rnd_comb", {req, stall, pcw, ifw, noop, flush}, exp);
         if (stl_e || (haz && start_i)) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
         if (!m_err) begin
            if (m_wait >= 0) begin
               if (ack) m_wait = -1;
               else begin
                  m_wait++;
                  if (m_wait == TMO) m_err = 1;
               end
            end else if (acc && !ack) m_wait = 0;
         end
         tick();
         chk("rnd_err", err, m_err);
         chk("rnd_cnt", cnt, m_cnt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
